// File: rtl/screen_write_bridge.sv
// Captures CPU writes that fall inside the screen window and forwards them as
// window-relative word offsets to the frame buffer through a small FWFT FIFO.
module screen_write_bridge #(
  parameter logic [15:0] SCREEN_BASE  = 16'h4000,
  parameter int          SCREEN_WORDS = 8192,
  parameter int          ADDR_W       = 13,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cpu_write,
  input  logic [15:0]                   cpu_addr,
  input  logic [15:0]                   cpu_data,
  output logic                          vram_valid,
  input  logic                          vram_ready,
  output logic [ADDR_W-1:0]             vram_addr,
  output logic [15:0]                   vram_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [15:0]                   drop_count,
  input  logic                          clear_stats
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENTRY_W = ADDR_W + 16;

  // Window bounds are held at 17 bits so BASE+WORDS never wraps to zero.
  localparam logic [16:0] WIN_LO = {1'b0, SCREEN_BASE};
  localparam logic [16:0] WIN_HI = WIN_LO + 17'(SCREEN_WORDS);

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   level;
  logic [ENTRY_W-1:0] head;
  logic [ADDR_W-1:0]  offset;
  logic               hit;
  logic               full;
  logic               pop;
  logic               push;
  logic               drop;

  always_comb begin
    hit    = cpu_write && ({1'b0, cpu_addr} >= WIN_LO) && ({1'b0, cpu_addr} < WIN_HI);
    offset = ADDR_W'(cpu_addr) - ADDR_W'(SCREEN_BASE);
    full   = (level == LVL_W'(FIFO_DEPTH));
    pop    = vram_valid && vram_ready;
    // A pop at the same edge frees the slot, so a full FIFO can still accept.
    push   = hit && (!full || pop);
    drop   = hit && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {offset, cpu_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear_stats) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

  // Empty FIFO presents zeros so stale RAM contents never leak out.
  always_comb begin
    head       = mem[rd_ptr];
    vram_valid = (level != '0);
    vram_addr  = vram_valid ? head[ENTRY_W-1:16] : '0;
    vram_data  = vram_valid ? head[15:0] : '0;
    fifo_level = level;
  end

endmodule
